// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-enabled data memory: FSM encoding and lane merge.
package dmem_pkg;

    localparam int unsigned MAX_WORD_W = 512;
    localparam int unsigned MAX_BE_W   = MAX_WORD_W / 8;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_IDLE = 1'b1;

    // Replace each byte of old_word whose enable bit is set with the byte from new_word.
    function automatic logic [MAX_WORD_W-1:0] byte_merge(
        input logic [MAX_WORD_W-1:0] old_word,
        input logic [MAX_WORD_W-1:0] new_word,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_WORD_W-1:0] res;
        res = old_word;
        for (int unsigned i = 0; i < MAX_BE_W; i++) begin
            if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_memory_be_if.sv
// Request/response bundle between the load/store unit and the data memory.
interface data_memory_be_if #(
    parameter int unsigned WORDSIZE = 64,
    parameter int unsigned SIZE     = 32,
    parameter int unsigned ADDR_W   = $clog2(SIZE),
    parameter int unsigned BE_W     = WORDSIZE / 8
) ();

    logic [ADDR_W-1:0]   addr;
    logic [WORDSIZE-1:0] data_input;
    logic [BE_W-1:0]     byte_en;
    logic                write_enable;
    logic                read;
    logic                clear;
    logic                ready;
    logic [WORDSIZE-1:0] data_output;
    logic                read_valid;
    logic                addr_error;

    modport master (
        output addr, data_input, byte_en, write_enable, read, clear,
        input  ready, data_output, read_valid, addr_error
    );

    modport slave (
        input  addr, data_input, byte_en, write_enable, read, clear,
        output ready, data_output, read_valid, addr_error
    );

endinterface

// File: rtl/dmem_byte_merge.sv
// Combinational byte-lane merge shared by the array write path and write-first read forwarding.
module dmem_byte_merge
    import dmem_pkg::*;
#(
    parameter int unsigned WORDSIZE = 64,
    parameter int unsigned BE_W     = WORDSIZE / 8
) (
    input  logic [WORDSIZE-1:0] old_word,
    input  logic [WORDSIZE-1:0] new_word,
    input  logic [BE_W-1:0]     be,
    output logic [WORDSIZE-1:0] merged_c
);

    assign merged_c = WORDSIZE'(byte_merge(MAX_WORD_W'(old_word),
                                           MAX_WORD_W'(new_word),
                                           MAX_BE_W'(be)));

endmodule

// File: rtl/data_memory_be.sv
// Single-port data RAM with byte enables, registered reads and a hardware zero-fill
// sequencer that runs after reset or on a clear request.
module data_memory_be
    import dmem_pkg::*;
#(
    parameter int unsigned WORDSIZE = 64,
    parameter int unsigned SIZE     = 32,
    parameter int unsigned ADDR_W   = $clog2(SIZE),
    parameter int unsigned BE_W     = WORDSIZE / 8
) (
    input logic              clk,
    input logic              rst_n,
    data_memory_be_if.slave  bus
);

    logic [WORDSIZE-1:0] mem_q [SIZE];

    logic [0:0]          state_q, state_d;
    logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
    logic                ready_q, ready_d;
    logic [WORDSIZE-1:0] dout_q, dout_d;
    logic                rv_q, rv_d;
    logic                aerr_q, aerr_d;

    logic                mem_we_d;
    logic [ADDR_W-1:0]   mem_waddr_d;
    logic [WORDSIZE-1:0] mem_wdata_d;

    logic                in_range;
    logic [ADDR_W-1:0]   rd_idx;
    logic [BE_W-1:0]     be_eff;
    logic [WORDSIZE-1:0] old_word;
    logic [WORDSIZE-1:0] merged_c;

    assign in_range = (32'(bus.addr) < SIZE);
    assign rd_idx   = in_range ? bus.addr : '0;
    assign old_word = mem_q[rd_idx];
    // A plain read merges with an all-zero mask, so the same word feeds both paths.
    assign be_eff   = bus.write_enable ? bus.byte_en : '0;

    dmem_byte_merge #(
        .WORDSIZE (WORDSIZE),
        .BE_W     (BE_W)
    ) u_merge (
        .old_word (old_word),
        .new_word (bus.data_input),
        .be       (be_eff),
        .merged_c (merged_c)
    );

    // Next-state, write-port and read-register logic.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        dout_d      = dout_q;
        rv_d        = 1'b0;
        aerr_d      = aerr_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = bus.addr;
        mem_wdata_d = merged_c;

        case (state_q)
            ST_INIT: begin
                mem_we_d    = 1'b1;
                mem_waddr_d = init_cnt_q;
                mem_wdata_d = '0;
                init_cnt_d  = init_cnt_q + ADDR_W'(1);
                if (init_cnt_q == ADDR_W'(SIZE - 1)) begin
                    state_d    = ST_IDLE;
                    init_cnt_d = '0;
                end
            end
            ST_IDLE: begin
                if (bus.clear) begin
                    state_d    = ST_INIT;
                    init_cnt_d = '0;
                    dout_d     = '0;
                end else begin
                    if (bus.write_enable || bus.read) aerr_d = ~in_range;
                    if (bus.write_enable && in_range) mem_we_d = 1'b1;
                    if (bus.read) begin
                        rv_d   = 1'b1;
                        dout_d = in_range ? merged_c : '0;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            ready_q    <= 1'b0;
            dout_q     <= '0;
            rv_q       <= 1'b0;
            aerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            ready_q    <= ready_d;
            dout_q     <= dout_d;
            rv_q       <= rv_d;
            aerr_q     <= aerr_d;
        end
    end

    // Storage is cleared by the fill sequencer rather than by reset.
    always_ff @(posedge clk) begin
        if (mem_we_d) mem_q[mem_waddr_d] <= mem_wdata_d;
    end

    assign bus.ready       = ready_q;
    assign bus.data_output = dout_q;
    assign bus.read_valid  = rv_q;
    assign bus.addr_error  = aerr_q;

endmodule
